commit_trace_buffer: RTL and testbench

- Parametrised commit-trace collector between the core's commit ports and the difftest/trace consumers.
- Accepts up to COMMIT_W retired instructions per cycle and compacts the valid slots in slot order into a FIFO.
- Drains the FIFO one instruction per cycle over a valid/ready port.
- Keeps a shadow architectural GPR file that is updated in program order as entries drain.

---
 rtl/commit_trace_pkg.sv | 37 +++
 rtl/commit_compactor.sv | 42 ++++
 rtl/commit_trace_buffer.sv | 145 ++++++++++++++
 tb/tb_commit_trace_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// Shared types for the commit-trace collector: entry struct, width constants, popcount helper.
// COMMIT_TRACE_TIMESTAMP_EN adds a per-entry cycle stamp to commit_entry_t.
package commit_trace_pkg;

  localparam int CT_COMMIT_W  = 4;
  localparam int CT_DEPTH     = 16;
  localparam int CT_XLEN      = 32;
  localparam int CT_NREG      = 32;
  localparam int MAX_COMMIT_W = 8;

  localparam int LDST_W = $clog2(CT_NREG);
  localparam int PTR_W  = $clog2(CT_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int CNT_W  = $clog2(MAX_COMMIT_W + 1);

  // Entry layout is fixed by CT_XLEN/CT_NREG; the top's XLEN/NREG must match them.
  typedef struct packed {
    logic [CT_XLEN-1:0] pc;
    logic [31:0]        instr;
    logic               wen;
    logic [LDST_W-1:0]  ldst;
    logic [CT_XLEN-1:0] wdata;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [63:0]        cycle;
`endif
  } commit_entry_t;

  function automatic logic [CNT_W-1:0] popcount_w(input logic [MAX_COMMIT_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_COMMIT_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/commit_compactor.sv
// Combinational slot compactor: packs valid commit slots, in slot order, into the low entries.
// Zero latency; no flow control of its own (the buffer decides whether the group is taken).
module commit_compactor
  import commit_trace_pkg::*;
#(
  parameter int COMMIT_W = CT_COMMIT_W
) (
  input  logic [COMMIT_W-1:0]         in_valid,
  input  logic [COMMIT_W*CT_XLEN-1:0] in_pc,
  input  logic [COMMIT_W*32-1:0]      in_instr,
  input  logic [COMMIT_W-1:0]         in_wen,
  input  logic [COMMIT_W*LDST_W-1:0]  in_ldst,
  input  logic [COMMIT_W*CT_XLEN-1:0] in_wdata,
  output commit_entry_t [COMMIT_W-1:0] ents,
  output logic [CNT_W-1:0]            count
);

  logic [CNT_W-1:0] pos;

  always_comb begin
    ents = '0;
    pos  = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (in_valid[i]) begin
        // pos is the rank of slot i among the valid slots below it
        for (int j = 0; j < COMMIT_W; j++) begin
          if (pos == CNT_W'(j)) begin
            ents[j].pc    = in_pc[i*CT_XLEN +: CT_XLEN];
            ents[j].instr = in_instr[i*32 +: 32];
            ents[j].wen   = in_wen[i];
            ents[j].ldst  = in_ldst[i*LDST_W +: LDST_W];
            ents[j].wdata = in_wdata[i*CT_XLEN +: CT_XLEN];
          end
        end
        pos = pos + CNT_W'(1);
      end
    end
  end

  assign count = popcount_w(MAX_COMMIT_W'(in_valid));

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace FIFO with shadow GPR file; entries visible one cycle after push, whole group dropped
// (sticky overflow) when fewer than COMMIT_W slots are free. COMMIT_TRACE_TIMESTAMP_EN adds out_cycle.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int COMMIT_W = CT_COMMIT_W,
  parameter int DEPTH    = CT_DEPTH,
  parameter int XLEN     = CT_XLEN,
  parameter int NREG     = CT_NREG
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COMMIT_W-1:0]        in_valid,
  input  logic [COMMIT_W*XLEN-1:0]   in_pc,
  input  logic [COMMIT_W*32-1:0]     in_instr,
  input  logic [COMMIT_W-1:0]        in_wen,
  input  logic [COMMIT_W*LDST_W-1:0] in_ldst,
  input  logic [COMMIT_W*XLEN-1:0]   in_wdata,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_wdata,
  output logic                       out_wen,
  output logic [LDST_W-1:0]          out_ldst,
  output logic [63:0]                out_seq,
  output logic [NREG*XLEN-1:0]       gpr_flat,
  output logic [$clog2(DEPTH):0]     occupancy,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  output logic [63:0]                out_cycle,
`endif
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int AW = OW + 1;

  commit_entry_t                mem [DEPTH];
  commit_entry_t [COMMIT_W-1:0] ents;
  commit_entry_t [COMMIT_W-1:0] wr_ents;
  commit_entry_t                head_ent;
  logic [CNT_W-1:0]             cnt;
  logic [PW-1:0]                head;
  logic [PW-1:0]                tail;
  logic [OW-1:0]                occ;
  logic [63:0]                  seq;
  logic                         ovf;
  logic                         any_valid;
  logic                         push;
  logic                         pop;
  logic [XLEN-1:0]              gpr [NREG];

  commit_compactor #(.COMMIT_W(COMMIT_W)) u_compactor (
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .in_wen   (in_wen),
    .in_ldst  (in_ldst),
    .in_wdata (in_wdata),
    .ents     (ents),
    .count    (cnt)
  );

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [63:0] cyc;

  always_ff @(posedge clk) begin
    if (!reset) cyc <= '0;
    else        cyc <= cyc + 64'd1;
  end

  always_comb begin
    wr_ents = ents;
    for (int k = 0; k < COMMIT_W; k++) begin
      wr_ents[k].cycle = cyc;
    end
  end

  assign out_cycle = head_ent.cycle;
`else
  assign wr_ents = ents;
`endif

  // Ready ignores a same-cycle pop so it depends only on registered state.
  assign in_ready  = (OW'(DEPTH) - occ) >= OW'(COMMIT_W);
  assign any_valid = |in_valid;
  assign push      = any_valid && in_ready;
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;

  assign head_ent  = mem[head];
  assign out_pc    = head_ent.pc;
  assign out_instr = head_ent.instr;
  assign out_wen   = head_ent.wen;
  assign out_ldst  = head_ent.ldst;
  assign out_wdata = head_ent.wdata;
  assign out_seq   = seq;
  assign occupancy = occ;
  assign overflow  = ovf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      seq  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(cnt);
      if (pop) begin
        head <= head + PW'(1);
        seq  <= seq + 64'd1;
      end
      occ <= occ + (push ? OW'(cnt) : OW'(0)) - (pop ? OW'(1) : OW'(0));
      if (any_valid && !in_ready) ovf <= 1'b1;
    end
  end

  // Storage holds no reset; pointer reset is enough to discard it.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (CNT_W'(k) < cnt) mem[tail + PW'(k)] <= wr_ents[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) gpr[r] <= '0;
    end else if (pop && head_ent.wen && head_ent.ldst != '0) begin
      gpr[head_ent.ldst] <= head_ent.wdata;
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_flat
    assign gpr_flat[r*XLEN +: XLEN] = gpr[r];
  end

  a_no_overfill: assert property (@(posedge clk) disable iff (!reset)
    push |-> ({1'b0, occ} + AW'(cnt) <= AW'(DEPTH)));

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench: a queue-based reference model tracks accepted entries, drops and the GPR file;
// a negedge monitor compares the DUT's head, occupancy, flags and gpr_flat against it every cycle.
module tb_commit_trace_buffer;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    in_valid;
  logic [127:0]  in_pc;
  logic [127:0]  in_instr;
  logic [3:0]    in_wen;
  logic [19:0]   in_ldst;
  logic [127:0]  in_wdata;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [31:0]   out_wdata;
  logic          out_wen;
  logic [4:0]    out_ldst;
  logic [63:0]   out_seq;
  logic [1023:0] gpr_flat;
  logic [4:0]    occupancy;
  logic          overflow;

  always #5 clk = ~clk;

  commit_trace_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_wen    (in_wen),
    .in_ldst   (in_ldst),
    .in_wdata  (in_wdata),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_wdata (out_wdata),
    .out_wen   (out_wen),
    .out_ldst  (out_ldst),
    .out_seq   (out_seq),
    .gpr_flat  (gpr_flat),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic        wen;
    logic [4:0]  ldst;
    logic [63:0] seq;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mg[32];
  logic        m_ovf;
  logic [63:0] push_seq;
  bit          started = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Reference model: 16-deep queue, group accepted only if 4 slots are free before the edge.
  always @(posedge clk) begin : model
    int   n;
    ent_t e;
    started = 1;
    if (!reset) begin
      q.delete();
      m_ovf    = 1'b0;
      push_seq = 64'd0;
      for (int r = 0; r < 32; r++) mg[r] = 32'd0;
    end else begin
      n = q.size();
      if (n != 0 && out_ready) begin
        e = q.pop_front();
        if (e.wen && e.ldst != 5'd0) mg[e.ldst] = e.wdata;
      end
      if (|in_valid) begin
        if (16 - n >= 4) begin
          for (int i = 0; i < 4; i++) begin
            if (in_valid[i]) begin
              e.pc    = in_pc[i*32 +: 32];
              e.instr = in_instr[i*32 +: 32];
              e.wdata = in_wdata[i*32 +: 32];
              e.wen   = in_wen[i];
              e.ldst  = in_ldst[i*5 +: 5];
              e.seq   = push_seq;
              push_seq++;
              q.push_back(e);
            end
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [1023:0] mgf;
    if (started) begin
      check("out_valid", 1024'(out_valid), 1024'(q.size() != 0));
      check("occupancy", 1024'(occupancy), 1024'(q.size()));
      check("in_ready", 1024'(in_ready), 1024'((16 - q.size()) >= 4));
      check("overflow", 1024'(overflow), 1024'(m_ovf));
      if (q.size() != 0) begin
        check("out_pc", 1024'(out_pc), 1024'(q[0].pc));
        check("out_instr", 1024'(out_instr), 1024'(q[0].instr));
        check("out_wen", 1024'(out_wen), 1024'(q[0].wen));
        check("out_ldst", 1024'(out_ldst), 1024'(q[0].ldst));
        check("out_wdata", 1024'(out_wdata), 1024'(q[0].wdata));
        check("out_seq", 1024'(out_seq), 1024'(q[0].seq));
      end
      for (int r = 0; r < 32; r++) mgf[r*32 +: 32] = mg[r];
      check("gpr_flat", gpr_flat, mgf);
    end
  end

  task automatic rand_slots();
    for (int i = 0; i < 4; i++) begin
      in_pc[i*32 +: 32]    = $urandom;
      in_instr[i*32 +: 32] = $urandom;
      in_wdata[i*32 +: 32] = $urandom;
      in_wen[i]            = 1'($urandom_range(0, 1));
      in_ldst[i*5 +: 5]    = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic set_slot(input int i, input logic [31:0] pc, input logic wen,
                          input logic [4:0] ldst, input logic [31:0] wdata);
    in_pc[i*32 +: 32]    = pc;
    in_wen[i]            = wen;
    in_ldst[i*5 +: 5]    = ldst;
    in_wdata[i*32 +: 32] = wdata;
  endtask

  task automatic step(input logic [3:0] v, input logic rdy);
    in_valid  = v;
    out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    int a;
    int b;
    reset     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    rand_slots();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset while entries are queued discards them.
    rand_slots();
    step(4'b0111, 1'b0);
    step(4'b0000, 1'b0);
    reset = 1'b0;
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    reset = 1'b1;
    step(4'b0000, 1'b0);

    // Sparse compaction of slots 1 and 3.
    rand_slots();
    set_slot(1, 32'h1c000004, 1'b0, 5'd0, 32'd0);
    set_slot(3, 32'h1c00000c, 1'b0, 5'd0, 32'd0);
    step(4'b1010, 1'b1);
    repeat (3) step(4'b0000, 1'b1);

    // Shadow register write, then an ignored write to r0.
    rand_slots();
    set_slot(0, 32'h1c000010, 1'b1, 5'd5, 32'hdeadbeef);
    set_slot(1, 32'h1c000014, 1'b1, 5'd0, 32'h00000001);
    step(4'b0011, 1'b1);
    repeat (3) step(4'b0000, 1'b1);

    // Fill to 16, fifth group dropped, overflow must survive draining.
    repeat (5) begin
      rand_slots();
      step(4'hf, 1'b0);
    end
    step(4'b0000, 1'b0);
    repeat (20) step(4'b0000, 1'b1);

    // Wrap-around from a clean pointer state: 14 in, 14 out, then 4 straddling the wrap.
    reset = 1'b0;
    step(4'b0000, 1'b0);
    reset = 1'b1;
    repeat (3) begin
      rand_slots();
      step(4'hf, 1'b0);
    end
    rand_slots();
    step(4'b0110, 1'b0);
    repeat (16) step(4'b0000, 1'b1);
    rand_slots();
    step(4'hf, 1'b0);
    step(4'b0000, 1'b0);
    repeat (6) step(4'b0000, 1'b1);

    // Random backpressure against two-slot commits.
    repeat (500) begin
      rand_slots();
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      step(4'((4'b0001 << a) | (4'b0001 << b)), 1'($urandom_range(0, 3) != 0));
    end
    repeat (20) step(4'b0000, 1'b1);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
